// File: rtl/if_prefetch_unit_if.sv
// Fetch-stage bus bundle: the instruction-memory request/response channel, the decode-side
// valid/ready channel, and the redirect inputs. master = prefetch unit, slave = its environment.
interface if_prefetch_unit_if #(
   parameter int XLEN            = 32,
   parameter int MAX_OUTSTANDING = 2
);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_instr;
   logic [XLEN-1:0] out_pc;
   logic [OW-1:0]   outstanding;

   modport master (
      input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
      output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, outstanding
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
      input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, outstanding
   );
endinterface

// File: rtl/if_prefetch_unit.sv
// Instruction prefetch stage: in-order fetch with variable memory latency, PC-tagged prefetch
// FIFO toward decode, and redirect flush that discards responses still in flight.
module if_prefetch_unit #(
   parameter int              XLEN            = 32,
   parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
   parameter int              DEPTH           = 4,
   parameter int              MAX_OUTSTANDING = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   if_prefetch_unit_if.master  bus
);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } entry_t;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] tag_q [MAX_OUTSTANDING];
   logic [TW-1:0]   tag_wr_q, tag_rd_q;
   logic [OW-1:0]   outst_q, outst_d;
   logic [OW-1:0]   drop_q, drop_d;
   entry_t          fifo_q [DEPTH];
   logic [AW-1:0]   wr_q, rd_q;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic redirect, req_valid, req_fire, rsp_fire, push, pop, fifo_nonempty;
   logic unused_pc_lsb;

   function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
      return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + TW'(1);
   endfunction

   assign redirect      = bus.redirect_valid;
   assign unused_pc_lsb = ^bus.redirect_pc[1:0];
   assign fifo_nonempty = (cnt_q != '0);

   // Every issued request reserves a FIFO slot unless it is already doomed to be dropped.
   assign req_valid = rst_n && !redirect
                      && (int'(outst_q) < MAX_OUTSTANDING)
                      && (int'(cnt_q) + int'(outst_q) - int'(drop_q) < DEPTH);
   assign req_fire  = req_valid && bus.imem_req_ready;
   assign rsp_fire  = bus.imem_rsp_valid && (outst_q != '0);
   assign push      = rsp_fire && (drop_q == '0) && !redirect;
   assign pop       = fifo_nonempty && bus.out_ready && !redirect;

   always_comb begin
      outst_d = outst_q + OW'(req_fire) - OW'(rsp_fire);
      drop_d  = drop_q;
      if (redirect)
         drop_d = outst_d;
      else if (rsp_fire && (drop_q != '0))
         drop_d = drop_q - OW'(1);

      fetch_pc_d = fetch_pc_q;
      if (redirect)
         fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
      else if (req_fire)
         fetch_pc_d = fetch_pc_q + XLEN'(4);

      cnt_d = cnt_q;
      if (redirect)
         cnt_d = '0;
      else if (push && !pop)
         cnt_d = cnt_q + CW'(1);
      else if (pop && !push)
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         tag_wr_q   <= '0;
         tag_rd_q   <= '0;
         outst_q    <= '0;
         drop_q     <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         cnt_q      <= cnt_d;
         if (req_fire) tag_wr_q <= tag_inc(tag_wr_q);
         if (rsp_fire) tag_rd_q <= tag_inc(tag_rd_q);
         if (redirect) begin
            wr_q <= '0;
            rd_q <= '0;
         end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
         end
      end
   end

   // Storage needs no reset: tags are read only while outstanding, entries only while counted.
   always_ff @(posedge clk) begin
      if (req_fire) tag_q[tag_wr_q] <= fetch_pc_q;
      if (push)     fifo_q[wr_q]    <= '{pc: tag_q[tag_rd_q], instr: bus.imem_rsp_data};
   end

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.out_valid      = fifo_nonempty;
   assign bus.out_instr      = fifo_nonempty ? fifo_q[rd_q].instr : '0;
   assign bus.out_pc         = fifo_nonempty ? fifo_q[rd_q].pc : '0;
   assign bus.outstanding    = outst_q;
endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: fixed-latency memory responder plus hand-derived
// cycle-by-cycle expectations for streaming, backpressure, latency limits, redirects and reset.
module tb_if_prefetch_unit;
   localparam int          XLEN = 32;
   localparam int          DEPTH = 4;
   localparam int          MAXO = 2;
   localparam logic [31:0] KEY  = 32'hC0DE_0013;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   if_prefetch_unit_if #(.XLEN(XLEN), .MAX_OUTSTANDING(MAXO)) bus ();

   if_prefetch_unit #(
      .XLEN(XLEN), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int ncmp = 0;
   int nfail = 0;
   int cyc = 0;
   int lat = 1;
   bit mem_en = 1'b1;
   logic [31:0] pend_addr[$];
   int          pend_due[$];

   function automatic logic [31:0] ins(input logic [31:0] a);
      return a ^ KEY;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Memory model: record each accepted request, answer it exactly lat cycles later.
   always @(negedge clk) begin
      if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
         pend_addr.push_back(bus.imem_req_addr);
         pend_due.push_back(cyc + lat);
      end
   end

   task automatic adv();
      @(posedge clk);
      #1;
      cyc++;
      if (mem_en) begin
         if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = ins(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      pend_addr.delete();
      pend_due.delete();
      mem_en = 1'b1;
      adv();
      adv();
      rst_n = 1'b1;
      cyc = 0;
      #1;
   endtask

   initial begin
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.out_ready      = 1'b1;
      #2;
      chk("rst_req_valid", bus.imem_req_valid, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_instr", bus.out_instr, 0);
      chk("rst_out_pc", bus.out_pc, 0);
      chk("rst_outstanding", bus.outstanding, 0);

      // Streaming, 1-cycle memory, decode always ready
      lat = 1;
      do_reset();
      chk("t1_req_valid0", bus.imem_req_valid, 1);
      chk("t1_addr0", bus.imem_req_addr, 0);
      adv();
      chk("t1_addr1", bus.imem_req_addr, 4);
      chk("t1_no_out_yet", bus.out_valid, 0);
      for (int k = 2; k < 8; k++) begin
         adv();
         chk("t1_addr", bus.imem_req_addr, 64'(4 * k));
         chk("t1_out_valid", bus.out_valid, 1);
         chk("t1_out_pc", bus.out_pc, 64'(4 * (k - 2)));
         chk("t1_out_instr", bus.out_instr, ins(32'(4 * (k - 2))));
         chk("t1_outst_bound", (bus.outstanding <= MAXO), 1);
      end

      // Backpressure: exactly DEPTH entries buffered, then in-order drain
      bus.out_ready = 1'b0;
      lat = 1;
      do_reset();
      adv(); adv();
      chk("t2_head_c2", bus.out_pc, 0);
      adv(); adv();
      chk("t2_full_stop", bus.imem_req_valid, 0);
      repeat (5) adv();
      chk("t2_hold_valid", bus.out_valid, 1);
      chk("t2_hold_pc", bus.out_pc, 0);
      chk("t2_hold_instr", bus.out_instr, ins(32'h0));
      chk("t2_hold_noreq", bus.imem_req_valid, 0);
      chk("t2_hold_outst", bus.outstanding, 0);
      adv();
      bus.out_ready = 1'b1;
      #1;
      for (int k = 0; k < 7; k++) begin
         chk("t2_drain_valid", bus.out_valid, 1);
         chk("t2_drain_pc", bus.out_pc, 64'(4 * k));
         chk("t2_drain_instr", bus.out_instr, ins(32'(4 * k)));
         adv();
      end

      // Latency 3: at most MAX_OUTSTANDING in flight
      bus.out_ready = 1'b1;
      lat = 3;
      do_reset();
      adv(); adv();
      chk("t3_c2_stall", bus.imem_req_valid, 0);
      chk("t3_c2_outst", bus.outstanding, 2);
      adv();
      chk("t3_c3_stall", bus.imem_req_valid, 0);
      adv();
      chk("t3_c4_req", bus.imem_req_valid, 1);
      chk("t3_c4_addr", bus.imem_req_addr, 8);
      chk("t3_c4_out_pc", bus.out_pc, 0);
      adv();
      chk("t3_c5_out_pc", bus.out_pc, 4);
      chk("t3_c5_addr", bus.imem_req_addr, 12);
      adv();
      chk("t3_c6_stall", bus.imem_req_valid, 0);
      chk("t3_c6_outst", bus.outstanding, 2);

      // Redirect to 0x100 with two in flight and two buffered
      bus.out_ready = 1'b0;
      lat = 3;
      do_reset();
      repeat (6) adv();
      chk("t4_pre_outst", bus.outstanding, 2);
      chk("t4_pre_head", bus.out_pc, 0);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h100;
      #1;
      chk("t4_redir_noreq", bus.imem_req_valid, 0);
      adv();
      bus.redirect_valid = 1'b0;
      #1;
      chk("t4_flushed", bus.out_valid, 0);
      chk("t4_flushed_pc", bus.out_pc, 0);
      chk("t4_outst_kept", bus.outstanding, 2);
      adv();
      chk("t4_new_req", bus.imem_req_valid, 1);
      chk("t4_new_addr", bus.imem_req_addr, 32'h100);
      adv(); adv();
      chk("t4_stale_dropped", bus.out_valid, 0);
      adv(); adv();
      chk("t4_first_valid", bus.out_valid, 1);
      chk("t4_first_pc", bus.out_pc, 32'h100);
      chk("t4_first_instr", bus.out_instr, ins(32'h100));

      // Redirect coincident with a pop and a response; target low bits ignored
      bus.out_ready = 1'b1;
      lat = 1;
      do_reset();
      adv(); adv();
      chk("t5_pre_pc", bus.out_pc, 0);
      chk("t5_pre_rsp", bus.imem_rsp_valid, 1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h203;
      #1;
      chk("t5_redir_noreq", bus.imem_req_valid, 0);
      adv();
      bus.redirect_valid = 1'b0;
      #1;
      chk("t5_pop_void", bus.out_valid, 0);
      chk("t5_req", bus.imem_req_valid, 1);
      chk("t5_addr", bus.imem_req_addr, 32'h200);
      chk("t5_outst", bus.outstanding, 0);
      adv(); adv();
      chk("t5_new_pc", bus.out_pc, 32'h200);
      chk("t5_new_instr", bus.out_instr, ins(32'h200));

      // Reset mid-stream, then a stale response after release
      bus.out_ready = 1'b1;
      lat = 3;
      do_reset();
      adv(); adv();
      chk("t6_pre_outst", bus.outstanding, 2);
      rst_n  = 1'b0;
      mem_en = 1'b0;
      pend_addr.delete();
      pend_due.delete();
      bus.imem_rsp_valid = 1'b0;
      #1;
      chk("t6_rst_req", bus.imem_req_valid, 0);
      chk("t6_rst_ov", bus.out_valid, 0);
      chk("t6_rst_pc", bus.out_pc, 0);
      chk("t6_rst_instr", bus.out_instr, 0);
      chk("t6_rst_outst", bus.outstanding, 0);
      adv();
      rst_n = 1'b1;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hBAD0_BAD0;
      #1;
      chk("t6_restart_req", bus.imem_req_valid, 1);
      chk("t6_restart_addr", bus.imem_req_addr, 0);
      adv();
      bus.imem_rsp_valid = 1'b0;
      #1;
      chk("t6_stale_ignored", bus.out_valid, 0);
      chk("t6_outst_after", bus.outstanding, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
